turn_scheduler: RTL and testbench

Sequences each game turn by arbitrating the single projectile engine between the local player (cat) and the remote player (dog, via UART link). Only the current turn owner's throw request is accepted. The block launches the throw, tracks the flight via the engine's busy flag, and enforces a per-turn countdown with forfeit. It then hands the turn over and publishes the turn count and owner to the rest of the design.

---
 rtl/turn_scheduler_if.sv | 19 +
 rtl/turn_scheduler.sv | 173 +++++++++++++++++
 tb/tb_turn_scheduler.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/turn_scheduler_if.sv
// Projectile engine handshake: the turn scheduler launches throws (master),
// the engine reports flight status back (slave).
interface turn_scheduler_if;
  logic       throw_start;
  logic [6:0] throw_power;
  logic       throw_busy;

  modport master (
    output throw_start,
    output throw_power,
    input  throw_busy
  );

  modport slave (
    input  throw_start,
    input  throw_power,
    output throw_busy
  );
endinterface

// File: rtl/turn_scheduler.sv
// Turn scheduler: arbitrates the single projectile engine between the local
// player (cat) and the remote player (dog), tracks each throw's flight, and
// hands the turn over. Publishes turn owner and completed-turn count.
//
// Build option TURN_TIMEOUT_EN: when defined, a per-turn countdown runs in
// AWAIT_THROW and an expired turn is forfeited. When undefined, the countdown
// is absent, seconds_left_o stays at TURN_SECONDS and forfeit_o is tied low.
module turn_scheduler #(
  parameter int unsigned TICKS_PER_SEC = 60_000_000,
  parameter int unsigned TURN_SECONDS  = 10,
  parameter int unsigned BUSY_WAIT_MAX = 255
) (
  input  logic             clk60MHz,
  input  logic             rst,
  input  logic             game_over_i,
  input  logic             local_req_i,
  input  logic [6:0]       local_power_i,
  input  logic             remote_req_i,
  input  logic [6:0]       remote_power_i,
  turn_scheduler_if.master eng_io,
  output logic             turn_owner_o,
  output logic [2:0]       turn_cnt_o,
  output logic [3:0]       seconds_left_o,
  output logic             turn_advance_o,
  output logic             forfeit_o
);

  // Busy-wait counter spans 0..BUSY_WAIT_MAX-1, so WAIT_BUSY lasts at most
  // BUSY_WAIT_MAX cycles.
  localparam int unsigned     BusyW     = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX) : 1;
  localparam logic [BusyW-1:0] BusyLast = BusyW'(BUSY_WAIT_MAX - 1);
  localparam logic [3:0]      SecReload = 4'(TURN_SECONDS);

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned     PresW    = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(TICKS_PER_SEC - 1);
`endif

  typedef enum logic [2:0] {
    StAwaitThrow,
    StLaunch,
    StWaitBusy,
    StInFlight,
    StSettle
  } state_e;

  state_e           state_q;
  logic             owner_q;
  logic [2:0]       cnt_q;
  logic [6:0]       power_q;
  logic             start_q;
  logic             advance_q;
  logic [BusyW-1:0] busy_cnt_q;

`ifdef TURN_TIMEOUT_EN
  logic [3:0]       secs_q;
  logic [PresW-1:0] presc_q;
  logic             flag_q;
  logic             forfeit_q;
`else
  logic             unused_ticks;
  assign unused_ticks = ^TICKS_PER_SEC;
`endif

  logic       owner_req;
  logic [6:0] owner_power;

  // Select the current turn owner's request; the other player is ignored.
  always_comb begin
    owner_req   = local_req_i;
    owner_power = local_power_i;
    if (owner_q) begin
      owner_req   = remote_req_i;
      owner_power = remote_power_i;
    end
  end

  // Turn sequencing FSM with all outputs registered.
  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q    <= StAwaitThrow;
      owner_q    <= 1'b0;
      cnt_q      <= 3'd0;
      power_q    <= 7'd0;
      start_q    <= 1'b0;
      advance_q  <= 1'b0;
      busy_cnt_q <= '0;
`ifdef TURN_TIMEOUT_EN
      secs_q     <= SecReload;
      presc_q    <= '0;
      flag_q     <= 1'b0;
      forfeit_q  <= 1'b0;
`endif
    end else begin
      start_q   <= 1'b0;
      advance_q <= 1'b0;
`ifdef TURN_TIMEOUT_EN
      forfeit_q <= 1'b0;
`endif
      unique case (state_q)
        StAwaitThrow: begin
          // game_over freezes everything here, countdown included.
          if (!game_over_i) begin
            // A request beats an expired countdown in the same cycle.
            if (owner_req) begin
              power_q <= owner_power;
              state_q <= StLaunch;
            end
`ifdef TURN_TIMEOUT_EN
            else if (secs_q == 4'd0) begin
              flag_q  <= 1'b1;
              state_q <= StSettle;
            end else if (presc_q == PresLast) begin
              // secs_q is nonzero here, so the decrement saturates at 0.
              presc_q <= '0;
              secs_q  <= secs_q - 4'd1;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
`endif
          end
        end
        StLaunch: begin
          start_q    <= 1'b1;
          busy_cnt_q <= '0;
          state_q    <= StWaitBusy;
        end
        StWaitBusy: begin
          if (eng_io.throw_busy) begin
            state_q <= StInFlight;
          end else if (busy_cnt_q == BusyLast) begin
            // Engine never acknowledged: give up, turn still advances.
            state_q <= StSettle;
          end else begin
            busy_cnt_q <= busy_cnt_q + 1'b1;
          end
        end
        StInFlight: begin
          if (!eng_io.throw_busy) begin
            state_q <= StSettle;
          end
        end
        StSettle: begin
          advance_q <= 1'b1;
          owner_q   <= ~owner_q;
          cnt_q     <= cnt_q + 3'd1;
`ifdef TURN_TIMEOUT_EN
          forfeit_q <= flag_q;
          flag_q    <= 1'b0;
          secs_q    <= SecReload;
          presc_q   <= '0;
`endif
          state_q   <= StAwaitThrow;
        end
        default: state_q <= StAwaitThrow;
      endcase
    end
  end

  assign eng_io.throw_start = start_q;
  assign eng_io.throw_power = power_q;
  assign turn_owner_o       = owner_q;
  assign turn_cnt_o         = cnt_q;
  assign turn_advance_o     = advance_q;
`ifdef TURN_TIMEOUT_EN
  assign seconds_left_o     = secs_q;
  assign forfeit_o          = forfeit_q;
`else
  assign seconds_left_o     = SecReload;
  assign forfeit_o          = 1'b0;
`endif

endmodule

// File: tb/tb_turn_scheduler.sv
// Self-checking bench for turn_scheduler. Expected launches and turn
// handovers are queued as stimulus is driven and matched against what a
// monitor observes on the DUT outputs.
module tb_turn_scheduler;

`ifdef TURN_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  typedef struct packed {
    logic       f;
    logic       owner;
    logic [2:0] cnt;
  } adv_t;

  logic       clk60MHz = 1'b0;
  logic       rst = 1'b1;
  logic       game_over = 1'b0;
  logic       local_req = 1'b0;
  logic [6:0] local_power = 7'd0;
  logic       remote_req = 1'b0;
  logic [6:0] remote_power = 7'd0;
  logic       turn_owner;
  logic [2:0] turn_cnt;
  logic [3:0] seconds_left;
  logic       turn_advance;
  logic       forfeit;

  turn_scheduler_if eng ();

  turn_scheduler #(
    .TICKS_PER_SEC(4),
    .TURN_SECONDS (3),
    .BUSY_WAIT_MAX(8)
  ) dut (
    .clk60MHz      (clk60MHz),
    .rst           (rst),
    .game_over_i   (game_over),
    .local_req_i   (local_req),
    .local_power_i (local_power),
    .remote_req_i  (remote_req),
    .remote_power_i(remote_power),
    .eng_io        (eng),
    .turn_owner_o  (turn_owner),
    .turn_cnt_o    (turn_cnt),
    .seconds_left_o(seconds_left),
    .turn_advance_o(turn_advance),
    .forfeit_o     (forfeit)
  );

  always #5 clk60MHz = ~clk60MHz;

  int tests_run = 0;
  int tests_failed = 0;
  int n_start = 0;
  int n_adv = 0;
  int n_forfeit = 0;

  adv_t       exp_adv[$];
  adv_t       obs_adv[$];
  logic [6:0] exp_pow[$];
  logic [6:0] obs_pow[$];

  logic       model_owner;
  logic [2:0] model_cnt;

  // Monitor: owner/count after a handover are captured one cycle after the pulse.
  logic adv_pending = 1'b0;
  logic adv_f = 1'b0;
  always begin
    @(posedge clk60MHz);
    #1;
    if (adv_pending) begin
      obs_adv.push_back('{f: adv_f, owner: turn_owner, cnt: turn_cnt});
      adv_pending = 1'b0;
    end
    if (turn_advance) begin
      adv_pending = 1'b1;
      adv_f = forfeit;
      n_adv++;
    end
    if (forfeit) n_forfeit++;
    if (eng.throw_start) begin
      n_start++;
      obs_pow.push_back(eng.throw_power);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    game_over = 1'b0;
    local_req = 1'b0;
    remote_req = 1'b0;
    eng.throw_busy = 1'b0;
    repeat (2) @(negedge clk60MHz);
    rst = 1'b0;
    model_owner = 1'b0;
    model_cnt = 3'd0;
    exp_adv.delete();
    obs_adv.delete();
    exp_pow.delete();
    obs_pow.delete();
  endtask

  // Engine model: wait for the launch strobe, then stay busy for busy_cycles.
  task automatic engine_throw(input int busy_cycles, output bit seen, output int lat);
    seen = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(negedge clk60MHz);
      if (eng.throw_start) begin
        seen = 1'b1;
        lat = i;
      end
    end
    if (seen && busy_cycles > 0) begin
      eng.throw_busy = 1'b1;
      repeat (busy_cycles) @(negedge clk60MHz);
      eng.throw_busy = 1'b0;
    end
  endtask

  task automatic wait_obs_adv(input int budget);
    for (int i = 0; i < budget && obs_adv.size() == 0; i++) @(negedge clk60MHz);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    local_req = 1'b1;
    local_power = 7'd55;
    repeat (3) @(negedge clk60MHz);
    tests_run += 6;
    if (turn_owner !== 1'b0) begin
      tests_failed++; $display("FAIL reset_owner: got %b expected 0", turn_owner);
    end
    if (turn_cnt !== 3'd0) begin
      tests_failed++; $display("FAIL reset_cnt: got %0d expected 0", turn_cnt);
    end
    if (seconds_left !== 4'd3) begin
      tests_failed++; $display("FAIL reset_secs: got %0d expected 3", seconds_left);
    end
    if (eng.throw_start !== 1'b0 || eng.throw_power !== 7'd0) begin
      tests_failed++;
      $display("FAIL reset_throw: got start=%b power=%0d expected 0/0",
               eng.throw_start, eng.throw_power);
    end
    if (turn_advance !== 1'b0) begin
      tests_failed++; $display("FAIL reset_advance: got %b expected 0", turn_advance);
    end
    if (forfeit !== 1'b0) begin
      tests_failed++; $display("FAIL reset_forfeit: got %b expected 0", forfeit);
    end
    local_req = 1'b0;
  endtask

  task automatic test_local_throw();
    bit seen; int lat; int s0; adv_t e, o; logic [6:0] ep, op;
    do_reset();
    s0 = n_start;
    local_req = 1'b1;
    local_power = 7'd42;
    exp_pow.push_back(7'd42);
    exp_adv.push_back('{f: 1'b0, owner: 1'b1, cnt: 3'd1});
    @(negedge clk60MHz);
    local_req = 1'b0;
    tests_run++;
    if (eng.throw_power !== 7'd42) begin
      tests_failed++; $display("FAIL basic_power_n1: got %0d expected 42", eng.throw_power);
    end
    engine_throw(5, seen, lat);
    tests_run++;
    if (lat !== 1) begin
      tests_failed++; $display("FAIL basic_start_latency: got %0d expected 1", lat);
    end
    wait_obs_adv(20);
    repeat (2) @(negedge clk60MHz);
    tests_run++;
    if (n_start - s0 !== 1) begin
      tests_failed++; $display("FAIL basic_start_count: got %0d expected 1", n_start - s0);
    end
    ep = exp_pow.pop_front();
    tests_run++;
    if (obs_pow.size() == 0) begin
      tests_failed++; $display("FAIL basic_power: got no launch expected power %0d", ep);
    end else begin
      op = obs_pow.pop_front();
      if (op !== ep) begin
        tests_failed++; $display("FAIL basic_power: got %0d expected %0d", op, ep);
      end
    end
    e = exp_adv.pop_front();
    tests_run++;
    if (obs_adv.size() == 0) begin
      tests_failed++; $display("FAIL basic_advance: got no turn_advance expected one");
    end else begin
      o = obs_adv.pop_front();
      if (o !== e) begin
        tests_failed++;
        $display("FAIL basic_advance: got f=%b owner=%b cnt=%0d expected f=%b owner=%b cnt=%0d",
                 o.f, o.owner, o.cnt, e.f, e.owner, e.cnt);
      end
    end
  endtask

  task automatic test_non_owner_timeout();
    int adv_at; int s0; logic [3:0] sec12; adv_t e, o;
    do_reset();
    s0 = n_start;
    adv_at = -1;
    sec12 = 4'hx;
    remote_req = 1'b1;
    remote_power = 7'd99;
    if (ToEn) exp_adv.push_back('{f: 1'b1, owner: 1'b1, cnt: 3'd1});
    for (int i = 1; i <= 30 && adv_at < 0; i++) begin
      @(negedge clk60MHz);
      if (i == 12) sec12 = seconds_left;
      if (turn_advance) begin
        adv_at = i;
        remote_req = 1'b0;
      end
    end
    remote_req = 1'b0;
    repeat (3) @(negedge clk60MHz);
    tests_run += 3;
    if (adv_at !== (ToEn ? 14 : -1)) begin
      tests_failed++;
      $display("FAIL timeout_cycle: got %0d expected %0d", adv_at, ToEn ? 14 : -1);
    end
    if (sec12 !== (ToEn ? 4'd0 : 4'd3)) begin
      tests_failed++;
      $display("FAIL timeout_secs12: got %0d expected %0d", sec12, ToEn ? 0 : 3);
    end
    if (n_start - s0 !== 0) begin
      tests_failed++; $display("FAIL timeout_no_start: got %0d expected 0", n_start - s0);
    end
    while (exp_adv.size() > 0) begin
      e = exp_adv.pop_front();
      tests_run++;
      if (obs_adv.size() == 0) begin
        tests_failed++; $display("FAIL timeout_advance: got no turn_advance expected one");
      end else begin
        o = obs_adv.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL timeout_advance: got f=%b owner=%b cnt=%0d expected f=%b owner=%b cnt=%0d",
                   o.f, o.owner, o.cnt, e.f, e.owner, e.cnt);
        end
      end
    end
    tests_run++;
    if (obs_adv.size() != 0) begin
      tests_failed++; $display("FAIL timeout_extra_adv: got %0d expected 0", obs_adv.size());
    end
  endtask

  task automatic test_req_at_zero();
    bit found; bit seen; int lat; int f0; adv_t e, o;
    do_reset();
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk60MHz);
      if (seconds_left == 4'd0) found = 1'b1;
    end
    tests_run++;
    if (found !== ToEn) begin
      tests_failed++; $display("FAIL zero_reached: got %b expected %b", found, ToEn);
    end
    f0 = n_forfeit;
    local_req = 1'b1;
    local_power = 7'd17;
    exp_adv.push_back('{f: 1'b0, owner: 1'b1, cnt: 3'd1});
    @(negedge clk60MHz);
    local_req = 1'b0;
    engine_throw(2, seen, lat);
    tests_run++;
    if (seen !== 1'b1) begin
      tests_failed++; $display("FAIL zero_launch: got start=%b expected 1", seen);
    end
    wait_obs_adv(20);
    repeat (2) @(negedge clk60MHz);
    tests_run += 2;
    if (n_forfeit - f0 !== 0) begin
      tests_failed++; $display("FAIL zero_no_forfeit: got %0d pulses expected 0", n_forfeit - f0);
    end
    e = exp_adv.pop_front();
    if (obs_adv.size() == 0) begin
      tests_failed++; $display("FAIL zero_advance: got no turn_advance expected one");
    end else begin
      o = obs_adv.pop_front();
      if (o !== e) begin
        tests_failed++;
        $display("FAIL zero_advance: got f=%b owner=%b cnt=%0d expected f=%b owner=%b cnt=%0d",
                 o.f, o.owner, o.cnt, e.f, e.owner, e.cnt);
      end
    end
  endtask

  task automatic test_busy_timeout();
    bit seen; int lat; int adv_lat; adv_t e, o;
    do_reset();
    local_req = 1'b1;
    local_power = 7'd5;
    exp_adv.push_back('{f: 1'b0, owner: 1'b1, cnt: 3'd1});
    @(negedge clk60MHz);
    local_req = 1'b0;
    engine_throw(0, seen, lat);
    adv_lat = -1;
    for (int i = 1; i <= 20 && adv_lat < 0; i++) begin
      @(negedge clk60MHz);
      if (turn_advance) adv_lat = i;
    end
    tests_run += 2;
    if (adv_lat !== 9) begin
      tests_failed++; $display("FAIL busy_timeout_latency: got %0d expected 9", adv_lat);
    end
    wait_obs_adv(5);
    e = exp_adv.pop_front();
    if (obs_adv.size() == 0) begin
      tests_failed++; $display("FAIL busy_timeout_advance: got no turn_advance expected one");
    end else begin
      o = obs_adv.pop_front();
      if (o !== e) begin
        tests_failed++;
        $display("FAIL busy_timeout_advance: got f=%b owner=%b cnt=%0d expected f=%b owner=%b cnt=%0d",
                 o.f, o.owner, o.cnt, e.f, e.owner, e.cnt);
      end
    end
  endtask

  task automatic test_eight_turns();
    bit seen; int lat; bit got_adv; logic [6:0] pw, ep, op; adv_t e, o;
    do_reset();
    for (int t = 0; t < 8; t++) begin
      pw = 7'(10 + t);
      // Both players request; only the owner's power may be launched.
      local_req = 1'b1;
      remote_req = 1'b1;
      local_power = model_owner ? 7'(100 + t) : pw;
      remote_power = model_owner ? pw : 7'(100 + t);
      exp_pow.push_back(pw);
      exp_adv.push_back('{f: 1'b0, owner: ~model_owner, cnt: model_cnt + 3'd1});
      model_owner = ~model_owner;
      model_cnt = model_cnt + 3'd1;
      @(negedge clk60MHz);
      local_req = 1'b0;
      remote_req = 1'b0;
      engine_throw(1, seen, lat);
      got_adv = 1'b0;
      for (int i = 0; i < 10 && !got_adv; i++) begin
        @(negedge clk60MHz);
        if (turn_advance) got_adv = 1'b1;
      end
      @(negedge clk60MHz);
    end
    repeat (2) @(negedge clk60MHz);
    while (exp_pow.size() > 0) begin
      ep = exp_pow.pop_front();
      tests_run++;
      if (obs_pow.size() == 0) begin
        tests_failed++; $display("FAIL turns_power: got no launch expected power %0d", ep);
      end else begin
        op = obs_pow.pop_front();
        if (op !== ep) begin
          tests_failed++; $display("FAIL turns_power: got %0d expected %0d", op, ep);
        end
      end
    end
    while (exp_adv.size() > 0) begin
      e = exp_adv.pop_front();
      tests_run++;
      if (obs_adv.size() == 0) begin
        tests_failed++; $display("FAIL turns_advance: got no turn_advance expected cnt=%0d", e.cnt);
      end else begin
        o = obs_adv.pop_front();
        if (o !== e) begin
          tests_failed++;
          $display("FAIL turns_advance: got f=%b owner=%b cnt=%0d expected f=%b owner=%b cnt=%0d",
                   o.f, o.owner, o.cnt, e.f, e.owner, e.cnt);
        end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    bit seen; int lat; bit got_adv; int a0; int s0;
    do_reset();
    local_req = 1'b1;
    local_power = 7'd20;
    @(negedge clk60MHz);
    local_req = 1'b0;
    engine_throw(1, seen, lat);
    got_adv = 1'b0;
    for (int i = 0; i < 10 && !got_adv; i++) begin
      @(negedge clk60MHz);
      if (turn_advance) got_adv = 1'b1;
    end
    @(negedge clk60MHz);
    remote_req = 1'b1;
    remote_power = 7'd33;
    @(negedge clk60MHz);
    remote_req = 1'b0;
    engine_throw(0, seen, lat);
    eng.throw_busy = 1'b1;
    repeat (3) @(negedge clk60MHz);
    a0 = n_adv;
    s0 = n_start;
    rst = 1'b1;
    @(negedge clk60MHz);
    tests_run += 4;
    if (turn_owner !== 1'b0 || turn_cnt !== 3'd0) begin
      tests_failed++;
      $display("FAIL rstflight_turn: got owner=%b cnt=%0d expected 0/0", turn_owner, turn_cnt);
    end
    if (eng.throw_power !== 7'd0 || eng.throw_start !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstflight_throw: got power=%0d start=%b expected 0/0",
               eng.throw_power, eng.throw_start);
    end
    if (seconds_left !== 4'd3 || turn_advance !== 1'b0 || forfeit !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstflight_outs: got secs=%0d adv=%b forfeit=%b expected 3/0/0",
               seconds_left, turn_advance, forfeit);
    end
    eng.throw_busy = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk60MHz);
    if (n_adv - a0 !== 0 || n_start - s0 !== 0) begin
      tests_failed++;
      $display("FAIL rstflight_pulses: got adv=%0d start=%0d expected 0/0", n_adv - a0, n_start - s0);
    end
  endtask

  task automatic test_game_over();
    int s0; int a0;
    do_reset();
    repeat (5) @(negedge clk60MHz);
    s0 = n_start;
    a0 = n_adv;
    game_over = 1'b1;
    local_req = 1'b1;
    local_power = 7'd77;
    repeat (20) @(negedge clk60MHz);
    tests_run += 2;
    if (seconds_left !== (ToEn ? 4'd2 : 4'd3)) begin
      tests_failed++;
      $display("FAIL gameover_secs: got %0d expected %0d", seconds_left, ToEn ? 2 : 3);
    end
    if (n_start - s0 !== 0 || n_adv - a0 !== 0) begin
      tests_failed++;
      $display("FAIL gameover_frozen: got start=%0d adv=%0d expected 0/0", n_start - s0, n_adv - a0);
    end
    game_over = 1'b0;
    local_req = 1'b0;
    repeat (2) @(negedge clk60MHz);
  endtask

  initial begin
    eng.throw_busy = 1'b0;
    test_reset();
    test_local_throw();
    test_non_owner_timeout();
    test_req_at_zero();
    test_busy_timeout();
    test_eight_turns();
    test_reset_in_flight();
    test_game_over();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

endmodule
